// File: rtl/output_deskew.sv
// Output deskew for the systolic array: delays lane i by S-1-i cycles so every
// lane of a beat appears together, then registers the aligned beat with frame tracking.
module output_deskew #(
  parameter int N = 2,
  parameter int S = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [S*N-1:0]         D,
  output logic [S*N-1:0]         Q,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [$clog2(S)-1:0]   beat_cnt
);

  localparam int CW = $clog2(S);
  localparam logic [CW-1:0] LAST_BEAT = CW'(S - 1);

  logic [S*N-1:0] aligned;
  logic [S-2:0]   vsr;
  logic [S-2:0]   vsr_nxt;
  logic           dv;

  for (genvar i = 0; i < S; i++) begin : g_lane
    localparam int DEPTH = S - 1 - i;
    logic [N-1:0] lane_in;
    assign lane_in = D[S*N-1-i*N -: N];

    if (DEPTH == 0) begin : g_pass
      assign aligned[S*N-1-i*N -: N] = lane_in;
    end else begin : g_dly
      logic [DEPTH*N-1:0] dly;
      logic [DEPTH*N-1:0] dly_nxt;
      if (DEPTH == 1) begin : g_one
        assign dly_nxt = lane_in;
      end else begin : g_many
        assign dly_nxt = {dly[(DEPTH-1)*N-1:0], lane_in};
      end
      // Lane data is free-running: only rst clears it, clear leaves it alone.
      always_ff @(posedge clk) begin
        if (rst) dly <= '0;
        else     dly <= dly_nxt;
      end
      assign aligned[S*N-1-i*N -: N] = dly[DEPTH*N-1 -: N];
    end
  end

  if (S == 2) begin : g_vsr_one
    assign vsr_nxt = in_valid;
  end else begin : g_vsr_many
    assign vsr_nxt = {vsr[S-3:0], in_valid};
  end

  assign dv = vsr[S-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      vsr       <= '0;
      Q         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      beat_cnt  <= '0;
    end else if (clear) begin
      // A beat maturing in the clear cycle is dropped and Q keeps its old value.
      vsr       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      vsr       <= vsr_nxt;
      out_valid <= dv;
      out_last  <= dv && (beat_cnt == LAST_BEAT);
      if (dv) begin
        Q        <= aligned;
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
    end
  end

endmodule
